// File: rtl/signal_conflict_monitor_pkg.sv
// rtl/signal_conflict_monitor_pkg.sv - shared types and constants for the lamp conflict monitor
package traffic_pkg;

    typedef enum logic [1:0] {
        NORMAL      = 2'd0,
        PENDING     = 2'd1,
        FAULT_FLASH = 2'd2,
        RECOVER     = 2'd3
    } state_t;

    localparam logic [1:0] FAULT_NONE     = 2'd0;
    localparam logic [1:0] FAULT_ONEHOT   = 2'd1;
    localparam logic [1:0] FAULT_CONFLICT = 2'd2;
    localparam logic [1:0] FAULT_STUCK    = 2'd3;

    localparam int NS_RED    = 5;
    localparam int NS_YELLOW = 4;
    localparam int NS_GREEN  = 3;
    localparam int EW_RED    = 2;
    localparam int EW_YELLOW = 1;
    localparam int EW_GREEN  = 0;

    localparam logic [5:0] LAMPS_ALL_RED = 6'b100100;

    // Counter width for a count that stays below p; never narrower than one bit.
    function automatic int cnt_w(input int p);
        return (p > 1) ? $clog2(p) : 1;
    endfunction

    function automatic logic is_onehot3(input logic [2:0] v);
        return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

endpackage

// File: rtl/signal_conflict_monitor_if.sv
// rtl/signal_conflict_monitor_if.sv - lamp command/drive bundle between controller and monitor
interface signal_conflict_monitor_if;
    logic       ns_red_i, ns_yellow_i, ns_green_i;
    logic       ew_red_i, ew_yellow_i, ew_green_i;
    logic       clear_fault;
    logic       ns_red_o, ns_yellow_o, ns_green_o;
    logic       ew_red_o, ew_yellow_o, ew_green_o;
    logic       fault;
    logic [1:0] fault_code;
    logic [7:0] fault_count;

    modport master (
        output ns_red_i, ns_yellow_i, ns_green_i, ew_red_i, ew_yellow_i, ew_green_i, clear_fault,
        input  ns_red_o, ns_yellow_o, ns_green_o, ew_red_o, ew_yellow_o, ew_green_o,
        input  fault, fault_code, fault_count
    );

    modport slave (
        input  ns_red_i, ns_yellow_i, ns_green_i, ew_red_i, ew_yellow_i, ew_green_i, clear_fault,
        output ns_red_o, ns_yellow_o, ns_green_o, ew_red_o, ew_yellow_o, ew_green_o,
        output fault, fault_code, fault_count
    );
endinterface

// File: rtl/signal_conflict_monitor_lamp_legality_check.sv
// rtl/signal_conflict_monitor_lamp_legality_check.sv - combinational legality check of a 6-bit lamp vector
module lamp_legality_check
    import traffic_pkg::*;
(
    input  logic [5:0] lamps,
    output logic       illegal,
    output logic [1:0] code
);
    logic onehot_bad;
    logic conflict;

    always_comb begin
        onehot_bad = !is_onehot3(lamps[NS_RED:NS_GREEN]) || !is_onehot3(lamps[EW_RED:EW_GREEN]);
        conflict   = !lamps[NS_RED] && !lamps[EW_RED];
        illegal    = onehot_bad || conflict;
        // Conflicting right-of-way is the more dangerous condition, so it wins.
        if (conflict)        code = FAULT_CONFLICT;
        else if (onehot_bad) code = FAULT_ONEHOT;
        else                 code = FAULT_NONE;
    end
endmodule

// File: rtl/signal_conflict_monitor.sv
// rtl/signal_conflict_monitor.sv - lamp conflict monitor with glitch filter and fault flash
// MONITOR_STUCK_EN adds detection of lamp commands frozen for STUCK_LIMIT cycles.
module signal_conflict_monitor
    import traffic_pkg::*;
#(
    parameter int FAULT_FILTER   = 2,
    parameter int FLASH_HALF     = 8,
    parameter int ALL_RED_CYCLES = 4,
    parameter int STUCK_LIMIT    = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    signal_conflict_monitor_if.slave bus
);
    localparam int FW = cnt_w(FAULT_FILTER);
    localparam int HW = cnt_w(FLASH_HALF);
    localparam int RW = cnt_w(ALL_RED_CYCLES);

    logic [5:0]    cmd;
    logic          illegal;
    logic [1:0]    chk_code;
    state_t        state, state_nxt;
    logic          fault_entry;
    logic [1:0]    entry_code;
    logic [FW-1:0] filt_cnt, filt_nxt;
    logic [HW-1:0] flash_cnt, flash_nxt;
    logic          flash_phase, phase_nxt;
    logic [RW-1:0] rec_cnt, rec_nxt;
    logic [5:0]    lamps, lamps_nxt;
    logic [1:0]    code_q, code_nxt;
    logic [7:0]    count_q, count_nxt;
    logic          stuck_hit;

    assign cmd = {bus.ns_red_i, bus.ns_yellow_i, bus.ns_green_i,
                  bus.ew_red_i, bus.ew_yellow_i, bus.ew_green_i};

    lamp_legality_check u_check (
        .lamps   (cmd),
        .illegal (illegal),
        .code    (chk_code)
    );

`ifdef MONITOR_STUCK_EN
    localparam int SW = cnt_w(STUCK_LIMIT);
    logic [SW-1:0] stuck_cnt;
    logic [5:0]    prev_cmd;

    assign stuck_hit = (state == NORMAL) && (cmd == prev_cmd) && (stuck_cnt == SW'(STUCK_LIMIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stuck_cnt <= '0;
            prev_cmd  <= '0;
        end else begin
            prev_cmd  <= cmd;
            stuck_cnt <= (state == NORMAL && state_nxt == NORMAL && cmd == prev_cmd)
                         ? stuck_cnt + SW'(1) : '0;
        end
    end
`else
    // Stuck detection compiled out; STUCK_LIMIT is always positive so this never fires.
    assign stuck_hit = (STUCK_LIMIT < 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RECOVER;
            filt_cnt    <= '0;
            flash_cnt   <= '0;
            flash_phase <= 1'b0;
            rec_cnt     <= '0;
            lamps       <= LAMPS_ALL_RED;
            code_q      <= FAULT_NONE;
            count_q     <= '0;
        end else begin
            state       <= state_nxt;
            filt_cnt    <= filt_nxt;
            flash_cnt   <= flash_nxt;
            flash_phase <= phase_nxt;
            rec_cnt     <= rec_nxt;
            lamps       <= lamps_nxt;
            code_q      <= code_nxt;
            count_q     <= count_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        fault_entry = 1'b0;
        entry_code  = chk_code;
        case (state)
            NORMAL: begin
                if (illegal) begin
                    if (FAULT_FILTER <= 1) begin
                        state_nxt   = FAULT_FLASH;
                        fault_entry = 1'b1;
                    end else begin
                        state_nxt = PENDING;
                    end
                end else if (stuck_hit) begin
                    state_nxt   = FAULT_FLASH;
                    fault_entry = 1'b1;
                    entry_code  = FAULT_STUCK;
                end
            end
            PENDING: begin
                if (!illegal) begin
                    state_nxt = NORMAL;
                end else if (filt_cnt == FW'(FAULT_FILTER - 1)) begin
                    state_nxt   = FAULT_FLASH;
                    fault_entry = 1'b1;
                end
            end
            FAULT_FLASH: begin
                if (bus.clear_fault && !illegal) state_nxt = RECOVER;
            end
            RECOVER: begin
                if (illegal) begin
                    state_nxt   = FAULT_FLASH;
                    fault_entry = 1'b1;
                end else if (rec_cnt == RW'(ALL_RED_CYCLES - 1)) begin
                    state_nxt = NORMAL;
                end
            end
            default: state_nxt = RECOVER;
        endcase
    end

    always_comb begin
        phase_nxt = flash_phase;
        flash_nxt = '0;
        if (state_nxt == FAULT_FLASH) begin
            if (state != FAULT_FLASH) begin
                phase_nxt = 1'b1;
            end else if (flash_cnt == HW'(FLASH_HALF - 1)) begin
                phase_nxt = !flash_phase;
            end else begin
                flash_nxt = flash_cnt + HW'(1);
            end
        end

        // Outputs only follow commands that were legal in a NORMAL/PENDING cycle.
        lamps_nxt = lamps;
        if (state_nxt == FAULT_FLASH)
            lamps_nxt = phase_nxt ? LAMPS_ALL_RED : 6'b000000;
        else if (state_nxt == RECOVER)
            lamps_nxt = LAMPS_ALL_RED;
        else if ((state == NORMAL || state == PENDING) && state_nxt == NORMAL)
            lamps_nxt = cmd;

        rec_nxt  = (state == RECOVER && state_nxt == RECOVER) ? rec_cnt + RW'(1) : '0;
        filt_nxt = (state_nxt != PENDING) ? '0 :
                   (state == PENDING)     ? filt_cnt + FW'(1) : FW'(1);

        code_nxt = code_q;
        if (fault_entry)                                     code_nxt = entry_code;
        else if (state == FAULT_FLASH && state_nxt == RECOVER) code_nxt = FAULT_NONE;

        count_nxt = (fault_entry && count_q != 8'hFF) ? count_q + 8'd1 : count_q;
    end

    assign bus.ns_red_o    = lamps[NS_RED];
    assign bus.ns_yellow_o = lamps[NS_YELLOW];
    assign bus.ns_green_o  = lamps[NS_GREEN];
    assign bus.ew_red_o    = lamps[EW_RED];
    assign bus.ew_yellow_o = lamps[EW_YELLOW];
    assign bus.ew_green_o  = lamps[EW_GREEN];
    assign bus.fault       = (state == FAULT_FLASH);
    assign bus.fault_code  = code_q;
    assign bus.fault_count = count_q;

endmodule

// File: tb/tb_signal_conflict_monitor.sv
// tb/tb_signal_conflict_monitor.sv - scoreboard bench for signal_conflict_monitor (honours MONITOR_STUCK_EN)
module tb_signal_conflict_monitor;

    localparam logic [5:0] RED2   = 6'b100100;
    localparam logic [5:0] DARK   = 6'b000000;
    localparam logic [5:0] V_NSG  = 6'b001100;
    localparam logic [5:0] V_CONF = 6'b001001;
    localparam logic [5:0] V_EWG  = 6'b100001;
    localparam logic [5:0] V_OH   = 6'b000100;

    typedef struct {
        logic [5:0] lamps;
        logic       fault;
        logic [1:0] code;
        logic [7:0] count;
        string      tag;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst;
    exp_t  sb[$];
    exp_t  e;
    int    vectors = 0;
    int    miscompares = 0;

    signal_conflict_monitor_if bus ();

    signal_conflict_monitor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [5:0] outs();
        return {bus.ns_red_o, bus.ns_yellow_o, bus.ns_green_o,
                bus.ew_red_o, bus.ew_yellow_o, bus.ew_green_o};
    endfunction

    function automatic logic [10:0] status();
        return {bus.fault, bus.fault_code, bus.fault_count};
    endfunction

    task automatic set_cmd(input logic [5:0] v, input logic clr);
        {bus.ns_red_i, bus.ns_yellow_i, bus.ns_green_i,
         bus.ew_red_i, bus.ew_yellow_i, bus.ew_green_i} = v;
        bus.clear_fault = clr;
    endtask

    // Called at a falling edge: apply a vector and queue what the outputs must show after the next rise.
    task automatic drive(input logic [5:0] v, input logic clr, input logic [5:0] el, input logic ef,
                         input logic [1:0] ec, input logic [7:0] en, input string tag);
        exp_t x;
        set_cmd(v, clr);
        x.lamps = el;
        x.fault = ef;
        x.code  = ec;
        x.count = en;
        x.tag   = tag;
        sb.push_back(x);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst && sb.size() > 0) begin
            e = sb.pop_front();
            expect_eq({e.tag, "_lamps"}, 32'(outs()), 32'(e.lamps));
            expect_eq({e.tag, "_status"}, 32'(status()), 32'({e.fault, e.code, e.count}));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        set_cmd(V_NSG, 1'b0);
        @(posedge clk);
        #1;
        expect_eq("reset_lamps", 32'(outs()), 32'(RED2));
        expect_eq("reset_status", 32'(status()), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) drive(V_NSG, 1'b0, RED2, 1'b0, 2'd0, 8'd0, "start_red");
        for (int i = 0; i < 3; i++) drive(V_NSG, 1'b0, V_NSG, 1'b0, 2'd0, 8'd0, "start_pass");

        drive(V_CONF, 1'b0, V_NSG, 1'b0, 2'd0, 8'd0, "glitch_hold");
        drive(V_EWG, 1'b0, V_EWG, 1'b0, 2'd0, 8'd0, "glitch_resume");
        drive(V_EWG, 1'b0, V_EWG, 1'b0, 2'd0, 8'd0, "glitch_steady");

        drive(V_CONF, 1'b0, V_EWG, 1'b0, 2'd0, 8'd0, "conf_pending");
        drive(V_CONF, 1'b0, RED2, 1'b1, 2'd2, 8'd1, "conf_fault");
        for (int i = 0; i < 7; i++) drive(V_CONF, 1'b0, RED2, 1'b1, 2'd2, 8'd1, "flash_on");
        for (int i = 0; i < 8; i++) drive(V_CONF, 1'b0, DARK, 1'b1, 2'd2, 8'd1, "flash_off");
        drive(V_OH, 1'b1, RED2, 1'b1, 2'd2, 8'd1, "clear_ignored");
        drive(V_EWG, 1'b1, RED2, 1'b0, 2'd0, 8'd1, "clear_taken");
        for (int i = 0; i < 4; i++) drive(V_EWG, 1'b0, RED2, 1'b0, 2'd0, 8'd1, "clear_red");
        for (int i = 0; i < 2; i++) drive(V_EWG, 1'b0, V_EWG, 1'b0, 2'd0, 8'd1, "clear_pass");

        drive(V_OH, 1'b0, V_EWG, 1'b0, 2'd0, 8'd1, "onehot_pending");
        drive(V_OH, 1'b0, RED2, 1'b1, 2'd1, 8'd2, "onehot_fault");
        for (int i = 0; i < 2; i++) drive(V_OH, 1'b0, RED2, 1'b1, 2'd1, 8'd2, "onehot_flash");
        drive(V_NSG, 1'b1, RED2, 1'b0, 2'd0, 8'd2, "clear2");
        drive(V_NSG, 1'b0, RED2, 1'b0, 2'd0, 8'd2, "recover2");
        drive(V_OH, 1'b0, RED2, 1'b1, 2'd1, 8'd3, "recover_illegal");
        for (int i = 0; i < 3; i++) drive(V_OH, 1'b0, RED2, 1'b1, 2'd1, 8'd3, "flash3");

        expect_eq("queue_drained", 32'(sb.size()), 32'd0);

        #2;
        set_cmd(V_NSG, 1'b0);
        rst = 1'b1;
        #1;
        expect_eq("async_reset_lamps", 32'(outs()), 32'(RED2));
        expect_eq("async_reset_status", 32'(status()), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) drive(V_NSG, 1'b0, RED2, 1'b0, 2'd0, 8'd0, "rst_red");
        for (int i = 0; i < 63; i++) drive(V_NSG, 1'b0, V_NSG, 1'b0, 2'd0, 8'd0, "hold");
`ifdef MONITOR_STUCK_EN
        drive(V_NSG, 1'b0, RED2, 1'b1, 2'd3, 8'd1, "stuck_fault");
        drive(V_NSG, 1'b0, RED2, 1'b1, 2'd3, 8'd1, "stuck_flash");
`else
        drive(V_NSG, 1'b0, V_NSG, 1'b0, 2'd0, 8'd0, "no_stuck");
        drive(V_NSG, 1'b0, V_NSG, 1'b0, 2'd0, 8'd0, "no_stuck_after");
`endif

        expect_eq("queue_final", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/signal_conflict_monitor.md
Name: signal_conflict_monitor

Overview:
- Downstream stage of the traffic light controller. It consumes the six lamp commands (NS/EW red/yellow/green) and drives the physical lamp outputs.
- Checks every cycle for illegal lamp combinations and filters short glitches between command updates.
- On a confirmed fault, latches a fault code and forces both directions to flashing red until the fault is cleared.
- After reset or fault clear, holds an all-red interval before passing commands through again.

Parameters:
- FAULT_FILTER, 2: consecutive illegal cycles needed to confirm a fault (minimum 1).
- FLASH_HALF, 8: cycles per on-phase and per off-phase of the fault red flash.
- ALL_RED_CYCLES, 4: length in cycles of the all-red interval in RECOVER.
- STUCK_LIMIT, 64: cycles of unchanged lamp commands before a stuck fault; used only with MONITOR_STUCK_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ns_red_i, ns_yellow_i, ns_green_i  in  1 each  NS lamp commands from the controller.
- ew_red_i, ew_yellow_i, ew_green_i  in  1 each  EW lamp commands.
- clear_fault  in  1  single-cycle request to leave the fault state.
- ns_red_o, ns_yellow_o, ns_green_o, ew_red_o, ew_yellow_o, ew_green_o  out  1 each  registered lamp drives.
- fault  out  1  high while in FAULT_FLASH.
- fault_code  out  2  0 = none, 1 = one-hot violation, 2 = conflicting right-of-way, 3 = stuck.
- fault_count  out  8  number of confirmed faults since reset; saturates at 255.

Behaviour:
- Reset (asynchronous, active-high, rst):
  - State = RECOVER.
  - ns_red_o = ew_red_o = 1; all other lamp outputs 0.
  - fault = 0, fault_code = 0, fault_count = 0, all counters 0.
- Illegal conditions, evaluated combinationally on the inputs each cycle:
  - one-hot violation: NS or EW does not have exactly one lamp set.
  - conflict: ns_red_i = 0 and ew_red_i = 0 in the same cycle.
  - If both are true, conflict takes priority (code 2).
- NORMAL:
  - Lamp outputs = inputs registered, 1-cycle latency.
  - Illegal cycle: go to PENDING with filter count = 1. Outputs hold the last legal value; illegal commands are never driven.
  - If FAULT_FILTER = 1, go directly to FAULT_FLASH instead.
- PENDING:
  - Outputs hold the last legal value.
  - Legal input cycle: return to NORMAL and load outputs from the inputs that cycle.
  - Illegal input cycle: increment the filter count. When the count reaches FAULT_FILTER, go to FAULT_FLASH, latch the code of the current cycle, and increment fault_count (saturating).
- FAULT_FLASH:
  - fault = 1. Yellow and green outputs are 0.
  - ns_red_o = ew_red_o = flash phase. Phase starts at 1 on entry and toggles every FLASH_HALF cycles.
  - clear_fault is honoured only if the inputs are legal in that same cycle; it then moves to RECOVER and clears fault_code.
  - clear_fault with illegal inputs is ignored; the state stays FAULT_FLASH.
- RECOVER:
  - Both reds = 1, all else 0, for ALL_RED_CYCLES cycles, then go to NORMAL.
  - The first NORMAL cycle samples the inputs.
  - An illegal input during RECOVER goes straight to FAULT_FLASH with no filtering, and increments fault_count.
- clear_fault is ignored in NORMAL, PENDING and RECOVER.
- All counters are sized with $clog2 of their parameter. None wrap past their limit; each resets on state entry.

Optional Feature:
- Macro: MONITOR_STUCK_EN.
- With the macro defined:
  - A stuck counter increments each NORMAL cycle in which the 6-bit input vector is unchanged from the previous cycle.
  - Any change in the vector, or any non-NORMAL state, resets the counter.
  - Reaching STUCK_LIMIT goes to FAULT_FLASH with code 3 (no filter) and increments fault_count.
- Without the macro: no stuck counter exists and code 3 is never produced.

Decomposition:
- Shared package traffic_pkg:
  - State enum: NORMAL, PENDING, FAULT_FLASH, RECOVER.
  - Fault code constants: FAULT_NONE, FAULT_ONEHOT, FAULT_CONFLICT, FAULT_STUCK.
  - Lamp vector bit-index constants.
- One sub-module, lamp_legality_check: combinational; takes the 6-bit lamp vector and returns the illegal flag and the 2-bit code.

Test Plan:
- Reset, then hold the inputs at NS green / EW red (001100) → all-red for 4 cycles; at cycle 5 the outputs equal 001100 with 1-cycle latency.
- Drive NS green + EW green (001001) for 1 cycle between legal vectors → no fault; outputs hold the previous legal value for that cycle.
- Drive 001001 for 2 cycles → fault = 1, fault_code = 2, fault_count = 1; reds toggle every 8 cycles, yellow and green stay 0.
- In fault, pulse clear_fault with illegal inputs (000100) → ignored. Then pulse it with legal 100001 → 4 all-red cycles, then outputs = 100001, fault_code = 0.
- Assert rst mid-flash → asynchronously all-red, fault = 0, fault_count = 0, state = RECOVER.
- With MONITOR_STUCK_EN, hold 001100 for 64 cycles in NORMAL → fault_code = 3. Without the macro, the same stimulus gives no fault.
